// File: rtl/read_bram.sv
// read_bram: issues credit-limited block-RAM reads and streams the returned words out through a FIFO.
// Optional READ_BRAM_DEBUG_EN adds a cycle counter and a per-transfer trace.
module read_bram #(
  parameter int DATA_WIDTH = 8,
  parameter int LOG_MAX_ITERS = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int LOG_MAX_ADDRESS = 16,
  parameter int RAM_LATENCY = 1,
  parameter int FIFO_SLOTS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              configure,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic [LOG_MAX_ADDRESS-1:0]        base_address,
  output logic [LOG_MAX_ADDRESS-1:0]        address_out,
  output logic                              read_out,
  input  logic [DATA_WIDTH-1:0]             data_in,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              valid_out,
  input  logic                              avail_in,
  output logic                              busy,
  output logic                              done
);
  localparam int AW = $clog2(FIFO_SLOTS);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LOG_MAX_ITERS-1:0] iters_q, iters_d;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_q, reads_d, nreads_q, nreads_d;
  logic [LOG_MAX_ADDRESS-1:0] base_q, base_d, addr_q, addr_d;
  logic [CW-1:0] credits_q, credits_d, count_q, count_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [RAM_LATENCY-1:0] pipe_q, pipe_d;
  logic done_q, done_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_SLOTS];
  logic issue, push, pop, drained;
  assign issue = (state_q == RUN) && (credits_q != '0);
  assign push = pipe_q[RAM_LATENCY-1];
  assign pop = (count_q != '0) && avail_in;
  assign drained = (state_q == DRAIN) && (pipe_q == '0) && (count_q == '0);
  assign read_out = issue;
  assign address_out = (state_q == RUN) ? addr_q : '0;
  assign valid_out = pop;
  assign data_out = mem_q[rd_q];
  assign done = done_q | drained;
  assign busy = (state_q != IDLE) && !drained;
  always_comb begin
    state_d = state_q;
    iters_d = iters_q;
    reads_d = reads_q;
    nreads_d = nreads_q;
    base_d = base_q;
    addr_d = addr_q;
    done_d = 1'b0;
    credits_d = credits_q - CW'(issue) + CW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    pipe_d = (pipe_q << 1) | RAM_LATENCY'(issue);
    if (state_q == IDLE && configure) begin
      iters_d = num_iters;
      reads_d = num_reads_per_iter;
      nreads_d = num_reads_per_iter;
      base_d = base_address;
      addr_d = base_address;
      done_d = (num_iters == '0) || (num_reads_per_iter == '0);
      state_d = done_d ? IDLE : RUN;
    end
    // last read of an iteration rewinds to base; last of the final iteration starts draining
    if (issue) begin
      if (reads_q == LOG_MAX_READS_PER_ITER'(1)) begin
        addr_d = base_q;
        reads_d = nreads_q;
        iters_d = iters_q - 1'b1;
        state_d = (iters_q == LOG_MAX_ITERS'(1)) ? DRAIN : RUN;
      end else begin
        addr_d = addr_q + 1'b1;
        reads_d = reads_q - 1'b1;
      end
    end
    if (drained) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      iters_q <= '0;
      reads_q <= '0;
      nreads_q <= '0;
      base_q <= '0;
      addr_q <= '0;
      credits_q <= CW'(FIFO_SLOTS);
      count_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      pipe_q <= '0;
      done_q <= 1'b0;
    end else begin
      assert (!(push && count_q == CW'(FIFO_SLOTS))) else $error("read_bram: write to full FIFO");
      state_q <= state_d;
      iters_q <= iters_d;
      reads_q <= reads_d;
      nreads_q <= nreads_d;
      base_q <= base_d;
      addr_q <= addr_d;
      credits_q <= credits_d;
      count_q <= count_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      pipe_q <= pipe_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= data_in;
  end
`ifdef READ_BRAM_DEBUG_EN
  logic [15:0] tics_q;
  always_ff @(posedge clk) begin
    if (!rst) tics_q <= '0;
    else begin
      tics_q <= tics_q + 1'b1;
      if (valid_out) $display("READ_BRAM: cycle %d, data_out %x", tics_q, data_out);
    end
  end
`else
`endif
endmodule

// File: tb/tb_read_bram.sv
// tb_read_bram: directed and randomized checks of read_bram against a queue-based transfer model.
module tb_read_bram;
  logic clk = 1'b0, rst = 1'b0, configure = 1'b0, avail_in = 1'b0;
  logic [15:0] num_iters = '0, num_reads = '0, base = '0, address_out;
  logic read_out, valid_out, busy, done;
  logic [7:0] data_in = '0, data_out;
  int checks = 0, errors = 0;
  int issued, popped, first_rd, last_rd, first_val, done_cyc;

  read_bram dut (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads), .base_address(base), .address_out(address_out),
    .read_out(read_out), .data_in(data_in), .data_out(data_out), .valid_out(valid_out),
    .avail_in(avail_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // one-cycle-latency RAM; returns a poison value when not read
  always @(posedge clk) data_in <= read_out ? ram(address_out) : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_addr"}, 32'(address_out), 0);
    chk({tag, "_read"}, 32'(read_out), 0);
    chk({tag, "_valid"}, 32'(valid_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic run(input int it, input int rd, input logic [15:0] b, input int hold,
                     input bit rnd, input int limit);
    logic [15:0] exp_addr[$];
    logic [7:0] exp_data[$];
    logic [15:0] a;
    bit zero;
    zero = (it == 0) || (rd == 0);
    if (!zero)
      for (int i = 0; i < it; i++)
        for (int j = 0; j < rd; j++) begin
          a = b + 16'(j);
          exp_addr.push_back(a);
          exp_data.push_back(ram(a));
        end
    issued = 0; popped = 0; first_rd = -1; last_rd = -1; first_val = -1; done_cyc = -1;
    @(posedge clk); #1;
    num_iters = 16'(it); num_reads = 16'(rd); base = b; configure = 1'b1; avail_in = 1'b0;
    for (int c = 1; c <= limit && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      configure = 1'b0;
      avail_in = (c <= hold) ? 1'b0 : rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (read_out) begin
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        issued++;
        chk("read_expected", 32'(exp_addr.size() > 0), 1);
        if (exp_addr.size() > 0) chk("address", 32'(address_out), 32'(exp_addr.pop_front()));
      end
      if (valid_out) begin
        if (first_val < 0) first_val = c;
        popped++;
        chk("valid_expected", 32'(exp_data.size() > 0), 1);
        if (exp_data.size() > 0) chk("data", 32'(data_out), 32'(exp_data.pop_front()));
      end
      chk("valid_needs_avail", 32'(valid_out && !avail_in), 0);
      chk("credit_bound", 32'(issued - popped <= 4), 1);
      chk("busy", 32'(busy), zero ? 0 : 32'(!done));
      if (done) done_cyc = c;
      if (hold > 0 && c == hold) chk("bp_issued", 32'(issued), 4);
    end
    chk("done_seen", 32'(done_cyc >= 0), 1);
    chk("addr_left", 32'(exp_addr.size()), 0);
    chk("data_left", 32'(exp_data.size()), 0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("busy_after", 32'(busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b1;
    // basic run with cycle-exact latency
    run(1, 4, 16'h0010, 0, 1'b0, 50);
    chk("t1_first_rd", 32'(first_rd), 1);
    chk("t1_last_rd", 32'(last_rd), 4);
    chk("t1_first_val", 32'(first_val), 3);
    chk("t1_done_cyc", 32'(done_cyc), 7);
    run(3, 2, 16'h0020, 0, 1'b0, 60);
    chk("t2_transfers", 32'(popped), 6);
    run(1, 8, 16'h0030, 10, 1'b0, 80);
    chk("t3_transfers", 32'(popped), 8);
    run(1, 4, 16'hFFFE, 0, 1'b0, 50);
    run(1, 0, 16'h0050, 0, 1'b0, 10);
    chk("t5_done_cyc", 32'(done_cyc), 1);
    chk("t5_reads", 32'(issued), 0);
    run(0, 3, 16'h0050, 0, 1'b0, 10);
    chk("t5b_done_cyc", 32'(done_cyc), 1);
    // reset mid-run with reads outstanding
    @(posedge clk); #1;
    num_iters = 16'd1; num_reads = 16'd8; base = 16'h0040; configure = 1'b1; avail_in = 1'b0;
    @(posedge clk); #1;
    configure = 1'b0;
    @(negedge clk);
    chk("t6_reading", 32'(read_out), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    avail_in = 1'b1;
    @(negedge clk);
    chk_idle_outputs("t6_after_reset");
    repeat (3) begin
      @(negedge clk);
      chk("t6_late_data_ignored", 32'(valid_out), 0);
    end
    run(2, 3, 16'h0060, 0, 1'b0, 60);
    chk("t6_recover", 32'(popped), 6);
    // randomized configurations with random backpressure
    for (int k = 0; k < 10; k++)
      run($urandom_range(1, 3), $urandom_range(1, 6), 16'($urandom), 0, 1'b1, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/read_bram.md
Name: read_bram

Overview:
Read-side counterpart of the block-RAM writer. Once configured, it generates address/read-enable sequences into a block RAM and captures the returned data, which arrives after a fixed latency. The data is buffered in an internal FIFO and forwarded downstream through the valid/avail handshake. Credit-based issue ensures no returned word is ever dropped.

Parameters:
DATA_WIDTH, 8, width of RAM words and output data
LOG_MAX_ITERS, 16, bits of the iteration counter
LOG_MAX_READS_PER_ITER, 16, bits of the reads-per-iteration counter
LOG_MAX_ADDRESS, 16, bits of the RAM address
RAM_LATENCY, 1, cycles from read_out to valid data_in (>=1)
FIFO_SLOTS, 4, internal FIFO depth (power of 2, >= RAM_LATENCY+2 for full throughput)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
configure  in  1  CONFIGURE: load config, start; honoured only in IDLE
num_iters  in  LOG_MAX_ITERS  CONFIGURE: iteration count
num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  CONFIGURE: reads per iteration
base_address  in  LOG_MAX_ADDRESS  CONFIGURE: first address of every iteration
address_out  out  LOG_MAX_ADDRESS  RAM: read address
read_out  out  1  RAM: read enable
data_in  in  DATA_WIDTH  RAM: read data, valid RAM_LATENCY cycles after read_out
data_out  out  DATA_WIDTH  OUT: data (FIFO head)
valid_out  out  1  OUT: transfer this cycle
avail_in  in  1  OUT: downstream can accept this cycle
busy  out  1  high from the cycle after configure until done
done  out  1  one-cycle pulse after the last word is transferred

Behaviour:
- Reset (rst=0 at posedge): state IDLE; counters, credits=FIFO_SLOTS, FIFO, and the in-flight pipe cleared. All outputs 0: address_out, read_out, valid_out, busy, done. Data_out is don't-care. A reset mid-operation aborts immediately; RAM data returning afterwards is discarded.
- FSM states:
  - IDLE: on configure -> RUN. Latch num_iters, num_reads_per_iter, base_address; addr_r<=base_address. If num_iters==0 or num_reads_per_iter==0, go to IDLE instead and pulse done next cycle with no reads issued.
  - RUN: read_out = (credits>0); address_out=addr_r. On each issue:
    - credits--; addr_r++ (wraps mod 2^LOG_MAX_ADDRESS).
    - Decrement the reads-remaining counter. When the last read of an iteration issues, restore addr_r<=base, reload reads, decrement iters.
    - When the last read of the last iteration issues -> DRAIN.
  - DRAIN: read_out=0. When the in-flight pipe is empty and the FIFO is empty (the last word was popped) -> IDLE, with done=1 for exactly one cycle and busy deasserted the same cycle.
- configure is ignored in RUN and DRAIN.
- Return path: a RAM_LATENCY-deep shift register tracks issued reads. When its tail bit is set, data_in is written to the FIFO at the end of that cycle and becomes visible at the head the next cycle.
- Output: valid_out = ~fifo_empty & avail_in. Data_out is the FIFO head. A pop occurs when valid_out=1. A popped credit is returned (credits++) on the following cycle's register update; a simultaneous issue and pop leaves credits unchanged net of the timing above.
- Credit invariant: fifo_count + in_flight + credits == FIFO_SLOTS at all times. Overflow is impossible; a write to a full FIFO is a design error, checked by assertion.
- Latency (RAM_LATENCY=1): configure in cycle 0; read_out in cycle 1; data_in in cycle 2; valid_out in cycle 3 if avail_in=1.
- Throughput: one read per cycle sustained when avail_in stays high and FIFO_SLOTS >= RAM_LATENCY+2.
- Address order per iteration: base, base+1, ..., base+N-1, wrapping modulo the address width.

Optional Feature:
READ_BRAM_DEBUG_EN
- Defined: adds a 16-bit tics cycle counter (reset 0). Every cycle with valid_out=1 does $display("READ_BRAM: cycle %d, data_out %x").
- Undefined: no counter, no display; the RTL is functionally identical.

Test Plan:
1. Basic run: num_iters=1, reads=4, base=0x10, RAM holds mem[a]=a, avail_in=1.
   - read_out in cycles 1-4 with addresses 0x10-0x13.
   - data_out 0x10,0x11,0x12,0x13 in cycles 3-6.
   - done pulses in cycle 7.
2. Multi-iteration: iters=3, reads=2, base=0x20 -> address sequence 20,21,20,21,20,21; 6 transfers in order; one done pulse.
3. Backpressure: iters=1, reads=8, avail_in=0 for 10 cycles, then 1.
   - Exactly 4 reads issued; read_out stays 0 until a pop.
   - All 8 words delivered in order, none lost or duplicated.
4. Address wrap: LOG_MAX_ADDRESS=4, base=0xE, reads=4 -> addresses E,F,0,1.
5. Zero config: num_reads_per_iter=0 -> no read_out, no valid_out; done 1 cycle after configure; busy stays 0.
6. Reset mid-run: assert rst=0 during RUN with 2 reads in flight.
   - All outputs 0 the next cycle; late data_in ignored.
   - A new configure then completes normally.
